bcd_calc_core: RTL and testbench
================================

# bcd_calc_core

Parametrised BCD calculator core that follows the keypad scanner and drives the display multiplexer. It accepts one-cycle key events, assembles a DIGITS-wide BCD operand, and latches a first operand and an operator. It computes add or subtract with a digit-serial BCD datapath, then presents either the entry or the result to the display path. It generalises the fixed 4-digit, add-only push/save/sum/mux chain with configurable width, subtraction with sign, overflow detection, result chaining and a busy/done handshake.

## Interface
- DIGITS, 4, number of BCD digits per operand and result; legal range 1..8.
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-low reset; sampled on the clk rising edge.
- key_valid  in  1  one-cycle pulse; key_code is valid in this cycle.
- key_code  in  4  encoding:
  - 0x0–0x9: digit.
  - 0xA: add.
  - 0xB: subtract.
  - 0xC: equals.
  - 0xD: clear.
  - 0xE–0xF: ignored.
- disp  out  DIGITS×4  packed [DIGITS-1:0][3:0]; BCD value for the display mux; digit 0 is the LSD.
- neg  out  1  the displayed result is negative.
- ovf  out  1  the displayed result overflowed (add carry-out of the MSD).
- busy  out  1  a calculation is in progress.
- done  out  1  one-cycle pulse when the result becomes valid.

## Operation
- States:
  - ENTER_A: entering the first operand.
  - ENTER_B: entering the second operand.
  - CALC: digit-serial add or subtract.
  - NEGATE: re-complement of a negative result.
  - SHOW: result displayed.
- Digit key, in ENTER_A or ENTER_B:
  - Shifts entry left one digit; the new digit goes to digit 0.
  - An entry counter tracks digits entered. Once it reaches DIGITS, further digits are ignored.
  - Leading zeros count as digits.
- Op key (add or subtract):
  - ENTER_A: A ← entry, op latched, entry and counter cleared, go to ENTER_B.
  - ENTER_B: replaces the latched op only.
  - SHOW with neg=0 and ovf=0: A ← result, op latched, entry cleared, go to ENTER_B (chaining).
  - SHOW with neg or ovf set: ignored.
- Equals key:
  - ENTER_B: go to CALC. An empty entry is treated as 0.
  - ENTER_A or SHOW: ignored.
- Digit key in SHOW: clears neg and ovf, entry ← that digit, counter = 1, go to ENTER_A.
- Clear key, any state including CALC and NEGATE:
  - Next cycle: ENTER_A, entry/A/result zero, neg=ovf=busy=0.
  - No done pulse is issued.
- CALC:
  - One digit per cycle, LSD first, through the single-digit BCD adder.
  - Add: operands A and B, carry-in 0.
  - Subtract: operands A and the 9's complement of B, initial carry-in 1 (ten's-complement).
  - After DIGITS cycles:
    - Add: ovf ← final carry.
    - Subtract, final carry 1: result is non-negative, neg=0.
    - Subtract, final carry 0: go to NEGATE.
- NEGATE: DIGITS cycles computing 0 − result, digit-serial, with the same adder. Then neg=1.
- Any other key during CALC or NEGATE is ignored.
- disp source by state:
  - ENTER_A, ENTER_B, CALC, NEGATE: current entry (B during calculation).
  - SHOW: result. On overflow, disp shows the low DIGITS digits.
- Reset values: state ENTER_A; disp=0, neg=0, ovf=0, busy=0, done=0; all internal registers 0.

## Timing
- Key accepted in cycle t (key_valid=1). The resulting register and output change is visible from cycle t+1.
- Equals accepted at t:
  - busy=1 during cycles t+1 .. t+DIGITS.
  - Add, or non-negative subtract: SHOW and done=1 at t+DIGITS+1, with busy=0 in that cycle.
  - Negative subtract: busy stays high for DIGITS more cycles; done at t+2·DIGITS+1.
- done is high for exactly one cycle. busy and done are never high together.
- rst=0 overrides key_valid in the same cycle.
- Reset mid-CALC aborts with no done pulse.
- key_valid arriving on back-to-back cycles is legal. Each event is processed independently.

## Structure
- Package calc_pkg holds:
  - the state enum (calc_state_t);
  - key-code localparams (KEY_ADD, KEY_SUB, KEY_EQ, KEY_CLR);
  - the op enum (OP_ADD, OP_SUB).
- Sub-module bcd_digit_add: combinational single-digit BCD adder.
  - Inputs: a[3:0], b[3:0], cin.
  - Outputs: s[3:0], cout.
  - It is instantiated once and shared by CALC and NEGATE.
- Core holds:
  - the FSM;
  - the entry, A and result shift registers, rotated one digit per cycle during CALC and NEGATE;
  - a digit counter of width $clog2(DIGITS+1).

## Test plan
All scenarios use DIGITS=4 unless noted.
- Keys 1,2,3,+,4,5,= → disp=0168, neg=0, ovf=0; done exactly 5 cycles after equals is accepted.
- 9,9,9,9,+,1,= → disp=0000, ovf=1; a following + is ignored and the state stays SHOW.
- 2,5,−,1,0,0,= → disp=0075, neg=1; done 9 cycles after equals; busy high for 8 cycles.
- Keys 1,2,3,4,5 → disp=1234 (fifth digit dropped). Then 7,+,8,=,+,5,= → chained result disp=0020.
- Clear during the 2nd CALC cycle → next cycle ENTER_A, disp=0000, busy=0, no done. Repeat with rst=0 mid-CALC for the same result.
- DIGITS=1: 7,+,5,= → disp=2, ovf=1; done 2 cycles after equals.

Source files
------------

// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared types and key codes for the BCD calculator core
package calc_pkg;

    typedef enum logic [2:0] {
        ENTER_A,
        ENTER_B,
        CALC,
        NEGATE,
        SHOW
    } calc_state_t;

    typedef enum logic {
        OP_ADD,
        OP_SUB
    } calc_op_t;

    localparam logic [3:0] KEY_ADD = 4'hA;
    localparam logic [3:0] KEY_SUB = 4'hB;
    localparam logic [3:0] KEY_EQ  = 4'hC;
    localparam logic [3:0] KEY_CLR = 4'hD;

endpackage

// File: rtl/bcd_calc_core_if.sv
// rtl/bcd_calc_core_if.sv - key event input and display/status outputs of the calculator
interface bcd_calc_core_if #(
    parameter int DIGITS = 4
);
    logic                   key_valid;
    logic [3:0]             key_code;
    logic [DIGITS-1:0][3:0] disp;
    logic                   neg;
    logic                   ovf;
    logic                   busy;
    logic                   done;

    modport master (
        output key_valid, key_code,
        input  disp, neg, ovf, busy, done
    );

    modport slave (
        input  key_valid, key_code,
        output disp, neg, ovf, busy, done
    );
endinterface

// File: rtl/bcd_digit_add.sv
// rtl/bcd_digit_add.sv - combinational single-digit BCD adder with carry
module bcd_digit_add (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);
    logic [4:0] raw;

    assign raw  = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
    assign cout = (raw > 5'd9);
    // Adding 6 modulo 16 is the same as subtracting 10 from the low nibble.
    assign s    = cout ? (raw[3:0] + 4'd6) : raw[3:0];
endmodule

// File: rtl/bcd_calc_core.sv
// rtl/bcd_calc_core.sv - keypad-driven BCD add/subtract calculator with digit-serial datapath
module bcd_calc_core
    import calc_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic              clk,
    input  logic              rst,
    bcd_calc_core_if.slave    bus
);
    localparam int CW = $clog2(DIGITS + 1);

    typedef logic [DIGITS-1:0][3:0] bcd_t;

    calc_state_t state;
    calc_op_t    op;
    bcd_t        entry;
    bcd_t        a_reg;
    bcd_t        result;
    logic        carry;
    logic [CW-1:0] dcnt;
    logic [CW-1:0] cnt;
    logic        neg_q;
    logic        ovf_q;
    logic        busy_q;
    logic        done_q;

    bcd_t        a_rot;
    bcd_t        entry_rot;
    bcd_t        res_shift;
    bcd_t        entry_push;
    bcd_t        entry_one;

    logic [3:0]  add_a;
    logic [3:0]  add_b;
    logic [3:0]  sum;
    logic        cout;

    logic        key_digit;
    logic        key_op;
    logic        last_digit;
    calc_op_t    key_opcode;

    assign key_digit  = bus.key_valid && (bus.key_code <= 4'd9);
    assign key_op     = bus.key_valid && ((bus.key_code == KEY_ADD) || (bus.key_code == KEY_SUB));
    assign key_opcode = (bus.key_code == KEY_SUB) ? OP_SUB : OP_ADD;
    assign last_digit = (dcnt == CW'(DIGITS - 1));

    // NEGATE computes 0 - result as 0 + nines(result) + 1, reusing the same adder.
    always_comb begin
        add_a = a_reg[0];
        add_b = (op == OP_SUB) ? (4'd9 - entry[0]) : entry[0];
        if (state == NEGATE) begin
            add_a = 4'd0;
            add_b = 4'd9 - result[0];
        end
    end

    bcd_digit_add u_add (
        .a    (add_a),
        .b    (add_b),
        .cin  (carry),
        .s    (sum),
        .cout (cout)
    );

    // Operands rotate so they are restored after DIGITS steps; result fills from the MSD end.
    always_comb begin
        a_rot      = a_reg;
        entry_rot  = entry;
        res_shift  = result;
        entry_push = entry;
        entry_one  = '0;
        for (int i = 0; i < DIGITS - 1; i++) begin
            a_rot[i]     = a_reg[i+1];
            entry_rot[i] = entry[i+1];
            res_shift[i] = result[i+1];
        end
        a_rot[DIGITS-1]     = a_reg[0];
        entry_rot[DIGITS-1] = entry[0];
        res_shift[DIGITS-1] = sum;
        for (int i = DIGITS - 1; i > 0; i--) begin
            entry_push[i] = entry[i-1];
        end
        entry_push[0] = bus.key_code;
        entry_one[0]  = bus.key_code;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= ENTER_A;
            op     <= OP_ADD;
            entry  <= '0;
            a_reg  <= '0;
            result <= '0;
            carry  <= 1'b0;
            dcnt   <= '0;
            cnt    <= '0;
            neg_q  <= 1'b0;
            ovf_q  <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (bus.key_valid && (bus.key_code == KEY_CLR)) begin
                state  <= ENTER_A;
                op     <= OP_ADD;
                entry  <= '0;
                a_reg  <= '0;
                result <= '0;
                carry  <= 1'b0;
                dcnt   <= '0;
                cnt    <= '0;
                neg_q  <= 1'b0;
                ovf_q  <= 1'b0;
                busy_q <= 1'b0;
            end else begin
                case (state)
                    ENTER_A, ENTER_B: begin
                        if (key_digit && (cnt != CW'(DIGITS))) begin
                            entry <= entry_push;
                            cnt   <= cnt + CW'(1);
                        end else if (key_op) begin
                            op <= key_opcode;
                            if (state == ENTER_A) begin
                                a_reg <= entry;
                                entry <= '0;
                                cnt   <= '0;
                                state <= ENTER_B;
                            end
                        end else if (bus.key_valid && (bus.key_code == KEY_EQ) && (state == ENTER_B)) begin
                            state  <= CALC;
                            busy_q <= 1'b1;
                            dcnt   <= '0;
                            carry  <= (op == OP_SUB);
                        end
                    end
                    CALC: begin
                        entry  <= entry_rot;
                        a_reg  <= a_rot;
                        result <= res_shift;
                        carry  <= cout;
                        dcnt   <= dcnt + CW'(1);
                        if (last_digit) begin
                            dcnt <= '0;
                            if ((op == OP_SUB) && !cout) begin
                                state <= NEGATE;
                                carry <= 1'b1;
                            end else begin
                                ovf_q  <= (op == OP_ADD) && cout;
                                neg_q  <= 1'b0;
                                state  <= SHOW;
                                busy_q <= 1'b0;
                                done_q <= 1'b1;
                            end
                        end
                    end
                    NEGATE: begin
                        result <= res_shift;
                        carry  <= cout;
                        dcnt   <= dcnt + CW'(1);
                        if (last_digit) begin
                            dcnt   <= '0;
                            neg_q  <= 1'b1;
                            state  <= SHOW;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                        end
                    end
                    SHOW: begin
                        if (key_digit) begin
                            neg_q <= 1'b0;
                            ovf_q <= 1'b0;
                            entry <= entry_one;
                            cnt   <= CW'(1);
                            state <= ENTER_A;
                        end else if (key_op && !neg_q && !ovf_q) begin
                            a_reg <= result;
                            op    <= key_opcode;
                            entry <= '0;
                            cnt   <= '0;
                            state <= ENTER_B;
                        end
                    end
                    default: state <= ENTER_A;
                endcase
            end
        end
    end

    assign bus.disp = (state == SHOW) ? result : entry;
    assign bus.neg  = neg_q;
    assign bus.ovf  = ovf_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
endmodule

// File: tb/tb_bcd_calc_core.sv
// tb/tb_bcd_calc_core.sv - directed scoreboard bench for bcd_calc_core at DIGITS=4 and DIGITS=1
module tb_bcd_calc_core;
    import calc_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    bcd_calc_core_if #(.DIGITS(4)) bus4 ();
    bcd_calc_core_if #(.DIGITS(1)) bus1 ();

    bcd_calc_core #(.DIGITS(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
    bcd_calc_core #(.DIGITS(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    typedef struct {
        logic [31:0] disp;
        logic        neg;
        logic        ovf;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] disp_of(input int sel);
        return (sel == 1) ? 32'(bus1.disp) : 32'(bus4.disp);
    endfunction

    // {neg, ovf, busy, done}
    function automatic logic [3:0] st_of(input int sel);
        return (sel == 1) ? {bus1.neg, bus1.ovf, bus1.busy, bus1.done}
                          : {bus4.neg, bus4.ovf, bus4.busy, bus4.done};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input int sel, input logic [3:0] code);
        if (sel == 1) begin
            bus1.key_valid = 1'b1;
            bus1.key_code  = code;
        end else begin
            bus4.key_valid = 1'b1;
            bus4.key_code  = code;
        end
        tick();
        bus1.key_valid = 1'b0;
        bus4.key_valid = 1'b0;
    endtask

    task automatic keys(input int sel, input string s);
        for (int i = 0; i < s.len(); i++) begin
            byte ch;
            ch = s[i];
            if (ch == "+")      press(sel, KEY_ADD);
            else if (ch == "-") press(sel, KEY_SUB);
            else if (ch == "=") press(sel, KEY_EQ);
            else if (ch == "c") press(sel, KEY_CLR);
            else                press(sel, 4'(ch - "0"));
        end
    endtask

    task automatic calc(input int sel, input string tag, input logic [31:0] d,
                        input logic n, input logic o, input int lat);
        exp_t e;
        int k;
        int busy_n;
        e.disp = d; e.neg = n; e.ovf = o; e.lat = lat;
        sb.push_back(e);
        press(sel, KEY_EQ);
        k = 1;
        busy_n = 0;
        while (!st_of(sel)[0] && k <= 40) begin
            if (st_of(sel)[1]) busy_n++;
            tick();
            k++;
        end
        e = sb.pop_front();
        check({tag, "_latency"}, 32'(k), 32'(e.lat));
        check({tag, "_busy_cycles"}, 32'(busy_n), 32'(e.lat - 1));
        check({tag, "_disp"}, disp_of(sel), e.disp);
        check({tag, "_neg"}, 32'(st_of(sel)[3]), 32'(e.neg));
        check({tag, "_ovf"}, 32'(st_of(sel)[2]), 32'(e.ovf));
        check({tag, "_busy_at_done"}, 32'(st_of(sel)[1]), 32'd0);
        tick();
        check({tag, "_done_width"}, 32'(st_of(sel)[0]), 32'd0);
    endtask

    task automatic watch_no_done(input string tag);
        int seen;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (st_of(0)[0] || st_of(0)[1]) seen++;
            tick();
        end
        check(tag, 32'(seen), 32'd0);
    endtask

    initial begin
        bus4.key_valid = 1'b0; bus4.key_code = 4'h0;
        bus1.key_valid = 1'b0; bus1.key_code = 4'h0;
        rst = 1'b0;
        // key pressed while reset is held must be dropped
        bus4.key_valid = 1'b1; bus4.key_code = 4'd7;
        repeat (3) @(posedge clk);
        #1;
        bus4.key_valid = 1'b0;
        check("reset_disp4", disp_of(0), 32'h0);
        check("reset_status4", 32'(st_of(0)), 32'h0);
        check("reset_disp1", disp_of(1), 32'h0);
        check("reset_status1", 32'(st_of(1)), 32'h0);
        rst = 1'b1;
        tick();

        keys(0, "123+45");
        check("entry_b", disp_of(0), 32'h0045);
        calc(0, "add_123_45", 32'h0168, 1'b0, 1'b0, 5);

        keys(0, "c9999+1");
        calc(0, "add_ovf", 32'h0000, 1'b0, 1'b1, 5);
        keys(0, "+=");
        check("ovf_chain_ignored_busy", 32'(st_of(0)[1]), 32'd0);
        check("ovf_chain_ignored_ovf", 32'(st_of(0)[2]), 32'd1);
        check("ovf_chain_ignored_disp", disp_of(0), 32'h0);
        keys(0, "2");
        check("digit_in_show_disp", disp_of(0), 32'h0002);
        check("digit_in_show_ovf", 32'(st_of(0)[2]), 32'd0);

        keys(0, "c25-100");
        calc(0, "sub_neg", 32'h0075, 1'b1, 1'b0, 9);
        keys(0, "c300-125");
        calc(0, "sub_pos", 32'h0175, 1'b0, 1'b0, 5);

        keys(0, "c12345");
        check("entry_limit", disp_of(0), 32'h1234);
        keys(0, "c7+8");
        calc(0, "chain_first", 32'h0015, 1'b0, 1'b0, 5);
        keys(0, "+5");
        calc(0, "chain_second", 32'h0020, 1'b0, 1'b0, 5);

        keys(0, "c1+2=");
        tick();
        press(0, KEY_CLR);
        check("clr_mid_calc_disp", disp_of(0), 32'h0);
        check("clr_mid_calc_status", 32'(st_of(0)), 32'h0);
        watch_no_done("clr_mid_calc_no_done");

        keys(0, "1+2=");
        tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check("rst_mid_calc_disp", disp_of(0), 32'h0);
        check("rst_mid_calc_status", 32'(st_of(0)), 32'h0);
        watch_no_done("rst_mid_calc_no_done");

        keys(1, "7+5");
        calc(1, "d1_add_ovf", 32'h2, 1'b0, 1'b1, 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
